// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter merging NUM_CH AXI-Stream transmit sources into one MAC tx stream.
// Enforces an idle gap after every frame and cuts frames that exceed MAX_BEATS.
module eth_tx_frame_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 0,
    parameter int MAX_BEATS  = 1522
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]            s_axis_tvalid,
    output logic [NUM_CH-1:0]            s_axis_tready,
    input  logic [NUM_CH-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [$clog2(NUM_CH):0]      m_axis_tchannel,
    output logic                         truncated
);

    localparam int GW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW  = $clog2(NUM_CH) + 1;
    localparam int CW  = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CW-1:0]  CNT_LIMIT = (MAX_BEATS > 0) ? CW'(MAX_BEATS - 1) : '0;
    localparam logic [CW-1:0]  CNT_SAT   = '1;
    localparam logic [GCW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GCW'(GAP_CYCLES - 1) : '0;
    localparam logic [GW-1:0]  LAST_CH   = GW'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, PASS, DROP, GAP} state_t;

    state_t                 state;
    logic [GW-1:0]          grant;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          next_ptr;
    logic [GW-1:0]          arb_pick;
    logic                   arb_found;
    logic [CW-1:0]          beat_cnt;
    logic [GCW-1:0]         gap_cnt;
    logic [DATA_WIDTH-1:0]  ch_data [NUM_CH];
    logic [2*NUM_CH-1:0]    cand_rot;
    logic                   src_valid;
    logic                   src_last;
    logic                   at_limit;
    logic                   m_hs;
    logic                   drop_end;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Rotate the candidate set so bit 0 is rr_ptr; the first set bit is the next owner.
    always_comb begin
        int pick_idx;
        pick_idx  = 0;
        arb_found = 1'b0;
        arb_pick  = '0;
        cand_rot  = {s_axis_tvalid & ch_enable, s_axis_tvalid & ch_enable} >> rr_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!arb_found && cand_rot[i]) begin
                arb_found = 1'b1;
                pick_idx  = int'(rr_ptr) + i;
                if (pick_idx >= NUM_CH) begin
                    pick_idx = pick_idx - NUM_CH;
                end
                arb_pick = GW'(pick_idx);
            end
        end
    end

    assign src_valid = s_axis_tvalid[grant];
    assign src_last  = s_axis_tlast[grant];
    assign at_limit  = (MAX_BEATS > 0) && (beat_cnt == CNT_LIMIT);
    assign next_ptr  = (grant == LAST_CH) ? '0 : grant + GW'(1);
    assign m_hs      = (state == PASS) && src_valid && m_axis_tready;
    assign drop_end  = (state == DROP) && src_valid && src_last;

    assign m_axis_tchannel = TW'(grant);

    // The owning channel is wired straight through so PASS adds no latency.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        case (state)
            PASS: begin
                m_axis_tdata         = ch_data[grant];
                m_axis_tvalid        = src_valid;
                m_axis_tlast         = src_last || at_limit;
                s_axis_tready[grant] = m_axis_tready;
            end
            DROP: begin
                s_axis_tready[grant] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            truncated <= 1'b0;
        end else begin
            truncated <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant    <= arb_pick;
                        beat_cnt <= '0;
                        state    <= PASS;
                    end
                end
                PASS: begin
                    if (m_hs) begin
                        if (src_last || at_limit) begin
                            rr_ptr   <= next_ptr;
                            beat_cnt <= '0;
                            gap_cnt  <= '0;
                            if (!src_last) begin
                                truncated <= 1'b1;
                                state     <= DROP;
                            end else if (GAP_CYCLES > 0) begin
                                state <= GAP;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (beat_cnt != CNT_SAT) begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                DROP: begin
                    // The cut frame's tail is swallowed so the source can move on.
                    if (drop_end) begin
                        if (GAP_CYCLES > 0) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GCW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter: a 3-channel instance with gap and truncation, plus a
// default-parameter instance; beats are checked against per-channel expected queues.
module tb_eth_tx_frame_arbiter;

    localparam int NCH  = 3;
    localparam int DW   = 8;
    localparam int GAP  = 12;
    localparam int MAXB = 8;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NCH-1:0]      ch_enable = '0;
    logic [NCH*DW-1:0]   s_tdata = '0;
    logic [NCH-1:0]      s_tvalid = '0;
    logic [NCH-1:0]      s_tready;
    logic [NCH-1:0]      s_tlast = '0;
    logic [DW-1:0]       m_tdata;
    logic                m_tvalid;
    logic                m_tready = 1'b0;
    logic                m_tlast;
    logic [2:0]          m_tchannel;
    logic                truncated;

    logic [1:0]          d0_ch_enable = 2'b11;
    logic [15:0]         d0_s_tdata = '0;
    logic [1:0]          d0_s_tvalid = '0;
    logic [1:0]          d0_s_tready;
    logic [1:0]          d0_s_tlast = '0;
    logic [7:0]          d0_m_tdata;
    logic                d0_m_tvalid;
    logic                d0_m_tready = 1'b0;
    logic                d0_m_tlast;
    logic [1:0]          d0_m_tchannel;
    logic                d0_truncated;

    always #5 clock = ~clock;

    eth_tx_frame_arbiter #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .MAX_BEATS(MAXB)
    ) dut (
        .clock(clock), .reset(reset), .ch_enable(ch_enable),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tchannel(m_tchannel),
        .truncated(truncated)
    );

    eth_tx_frame_arbiter dut0 (
        .clock(clock), .reset(reset), .ch_enable(d0_ch_enable),
        .s_axis_tdata(d0_s_tdata), .s_axis_tvalid(d0_s_tvalid), .s_axis_tready(d0_s_tready),
        .s_axis_tlast(d0_s_tlast), .m_axis_tdata(d0_m_tdata), .m_axis_tvalid(d0_m_tvalid),
        .m_axis_tready(d0_m_tready), .m_axis_tlast(d0_m_tlast), .m_axis_tchannel(d0_m_tchannel),
        .truncated(d0_truncated)
    );

    int n_vec = 0;
    int n_err = 0;

    // Source-side beats still to be offered, and downstream beats still expected ({last, data}).
    logic [8:0]     src_q [NCH][$];
    logic [8:0]     exp_q [NCH][$];
    logic [NCH-1:0] accepted = '0;
    int             exp_trunc = 0;

    logic           o_valid, o_last, o_trunc, o_hs;
    logic [DW-1:0]  o_data;
    logic [NCH-1:0] o_sready;
    int             o_ch;

    task automatic clear_tb();
        for (int c = 0; c < NCH; c++) begin
            src_q[c].delete();
            exp_q[c].delete();
        end
        s_tvalid  = '0;
        s_tlast   = '0;
        s_tdata   = '0;
        accepted  = '0;
        m_tready  = 1'b0;
        exp_trunc = 0;
    endtask

    // A frame longer than MAXB is expected to appear as its first MAXB beats, the last one marked.
    task automatic load_frame(input int ch, input int len, input bit rnd, input logic [7:0] base);
        logic [7:0] d;
        for (int k = 0; k < len; k++) begin
            d = rnd ? 8'($urandom) : base + 8'(k);
            src_q[ch].push_back({(k == len - 1), d});
            if (k < MAXB) exp_q[ch].push_back({(k == len - 1) || (k == MAXB - 1), d});
        end
        if (len > MAXB) exp_trunc++;
    endtask

    task automatic drive_cycle(input int vpct, input int rpct, input int epct);
        @(negedge clock);
        for (int c = 0; c < NCH; c++) begin
            if (accepted[c]) begin
                void'(src_q[c].pop_front());
                s_tvalid[c] = 1'b0;
                s_tlast[c]  = 1'b0;
                accepted[c] = 1'b0;
            end
            if (!s_tvalid[c] && src_q[c].size() > 0 && $urandom_range(99) < vpct) begin
                s_tvalid[c]          = 1'b1;
                s_tdata[c*DW +: DW]  = src_q[c][0][7:0];
                s_tlast[c]           = src_q[c][0][8];
            end
            ch_enable[c] = ($urandom_range(99) < epct);
        end
        m_tready = ($urandom_range(99) < rpct);
        #1;
        o_valid  = m_tvalid;
        o_last   = m_tlast;
        o_data   = m_tdata;
        o_trunc  = truncated;
        o_ch     = int'(m_tchannel);
        o_sready = s_tready;
        o_hs     = m_tvalid && m_tready;
        for (int c = 0; c < NCH; c++) begin
            if (s_tvalid[c] && s_tready[c]) accepted[c] = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        s_tvalid  = 3'b011;
        s_tlast   = 3'b011;
        s_tdata   = 24'h00A5A5;
        ch_enable = '1;
        m_tready  = 1'b1;
        @(negedge clock);
        #1;
        n_vec++; if (m_tvalid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tvalid: got %b want 0", m_tvalid); end
        n_vec++; if (m_tlast !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tlast: got %b want 0", m_tlast); end
        n_vec++; if (m_tdata !== 8'h00) begin n_err++; $display("[TB] FAIL reset_tdata: got %h want 00", m_tdata); end
        n_vec++; if (m_tchannel !== 3'd0) begin n_err++; $display("[TB] FAIL reset_tchannel: got %0d want 0", m_tchannel); end
        n_vec++; if (truncated !== 1'b0) begin n_err++; $display("[TB] FAIL reset_truncated: got %b want 0", truncated); end
        n_vec++; if (s_tready !== 3'b000) begin n_err++; $display("[TB] FAIL reset_tready: got %b want 000", s_tready); end
        clear_tb();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        int nb = 0;
        clear_tb();
        load_frame(0, 4, 1'b0, 8'h01);
        for (int i = 0; i < 12; i++) begin
            drive_cycle(100, 100, 100);
            if (o_hs) begin
                if (nb == 0) begin
                    n_vec++; if (i != 1) begin n_err++; $display("[TB] FAIL t1_grant_latency: first beat in cycle %0d want 1", i); end
                end
                n_vec++;
                if (o_data !== 8'h01 + 8'(nb) || o_last !== (nb == 3) || o_ch != 0) begin
                    n_err++;
                    $display("[TB] FAIL t1_beat%0d: got data %h last %b ch %0d want data %h last %b ch 0",
                             nb, o_data, o_last, o_ch, 8'h01 + 8'(nb), (nb == 3));
                end
                nb++;
            end
        end
        n_vec++; if (nb != 4) begin n_err++; $display("[TB] FAIL t1_beat_count: got %0d want 4", nb); end
        repeat (16) drive_cycle(100, 100, 100);
    endtask

    task automatic test_round_robin();
        int nb = 0, exp_ch = 1, frame_ch = 0, c;
        bit in_frame = 0;
        clear_tb();
        for (int f = 0; f < 3; f++) begin
            load_frame(0, 3, 1'b0, 8'h10 + 8'(f * 16));
            load_frame(1, 3, 1'b0, 8'h90 + 8'(f * 16));
        end
        for (int i = 0; i < 300 && nb < 18; i++) begin
            drive_cycle(100, 100, 100);
            if (o_hs) begin
                c = o_ch;
                if (!in_frame) begin
                    n_vec++; if (c != exp_ch) begin n_err++; $display("[TB] FAIL t2_order: frame on ch %0d want ch %0d", c, exp_ch); end
                    frame_ch = c;
                end else begin
                    n_vec++; if (c != frame_ch) begin n_err++; $display("[TB] FAIL t2_interleave: beat on ch %0d want ch %0d", c, frame_ch); end
                end
                n_vec++;
                if (c >= NCH || exp_q[c].size() == 0) begin
                    n_err++; $display("[TB] FAIL t2_unexpected: beat %h on ch %0d, none expected", o_data, c);
                end else begin
                    if ({o_last, o_data} !== exp_q[c][0]) begin
                        n_err++; $display("[TB] FAIL t2_data: got %h want %h", {o_last, o_data}, exp_q[c][0]);
                    end
                    void'(exp_q[c].pop_front());
                end
                in_frame = !o_last;
                if (o_last) exp_ch = (c == 0) ? 1 : 0;
                nb++;
            end
        end
        n_vec++; if (nb != 18) begin n_err++; $display("[TB] FAIL t2_beat_count: got %0d want 18", nb); end
        repeat (16) drive_cycle(100, 100, 100);
    endtask

    task automatic test_gap();
        int t1 = -1, t2 = -1, low = 0;
        clear_tb();
        load_frame(0, 2, 1'b0, 8'h50);
        load_frame(0, 2, 1'b0, 8'h58);
        for (int i = 0; i < 50; i++) begin
            drive_cycle(100, 100, 100);
            if (t1 >= 0 && t2 < 0) begin
                if (o_hs) t2 = i;
                else if (!o_valid) low++;
            end else if (t1 < 0 && o_hs && o_last) begin
                t1 = i;
            end
        end
        n_vec++; if (t2 < 0) begin n_err++; $display("[TB] FAIL t3_second_frame: not seen within budget, want seen"); end
        n_vec++; if (t2 - t1 != GAP + 2) begin n_err++; $display("[TB] FAIL t3_spacing: got %0d cycles want %0d", t2 - t1, GAP + 2); end
        n_vec++; if (low != GAP + 1) begin n_err++; $display("[TB] FAIL t3_idle_cycles: got %0d want %0d", low, GAP + 1); end
        repeat (16) drive_cycle(100, 100, 100);
    endtask

    task automatic test_truncation();
        int nb = 0, ntr = 0, t8 = -1, ttr = -1;
        clear_tb();
        load_frame(1, 20, 1'b0, 8'h40);
        for (int i = 0; i < 60; i++) begin
            drive_cycle(100, 100, 100);
            if (o_hs) begin
                n_vec++;
                if (o_data !== 8'h40 + 8'(nb) || o_last !== (nb == MAXB - 1) || o_ch != 1) begin
                    n_err++;
                    $display("[TB] FAIL t4_beat%0d: got data %h last %b ch %0d want data %h last %b ch 1",
                             nb, o_data, o_last, o_ch, 8'h40 + 8'(nb), (nb == MAXB - 1));
                end
                nb++;
                if (nb == MAXB) t8 = i;
            end
            if (o_trunc) begin
                ntr++;
                ttr = i;
            end
        end
        n_vec++; if (nb != MAXB) begin n_err++; $display("[TB] FAIL t4_beats_out: got %0d want %0d", nb, MAXB); end
        n_vec++; if (ntr != 1) begin n_err++; $display("[TB] FAIL t4_trunc_pulses: got %0d want 1", ntr); end
        n_vec++; if (ttr != t8 + 1) begin n_err++; $display("[TB] FAIL t4_trunc_timing: pulse cycle %0d want %0d", ttr, t8 + 1); end
        n_vec++; if (src_q[1].size() != 0) begin n_err++; $display("[TB] FAIL t4_drop: %0d source beats left want 0", src_q[1].size()); end
    endtask

    task automatic test_random();
        int c, frame_ch = 0, ntr = 0;
        bit in_frame = 0, done = 0;
        clear_tb();
        for (int f = 0; f < 200; f++) begin
            load_frame(int'($urandom_range(NCH - 1)), int'($urandom_range(12, 1)), 1'b1, 8'h00);
        end
        for (int i = 0; i < 40000 && !done; i++) begin
            drive_cycle(60, 70, 80);
            if (o_trunc) ntr++;
            if (o_hs) begin
                c = o_ch;
                if (in_frame) begin
                    n_vec++; if (c != frame_ch) begin n_err++; $display("[TB] FAIL t5_interleave: beat on ch %0d want ch %0d", c, frame_ch); end
                end
                n_vec++;
                if (c >= NCH || exp_q[c].size() == 0) begin
                    n_err++; $display("[TB] FAIL t5_unexpected: beat %h on ch %0d, none expected", o_data, c);
                end else begin
                    if ({o_last, o_data} !== exp_q[c][0]) begin
                        n_err++; $display("[TB] FAIL t5_data_ch%0d: got %h want %h", c, {o_last, o_data}, exp_q[c][0]);
                    end
                    void'(exp_q[c].pop_front());
                end
                in_frame = !o_last;
                frame_ch = c;
            end
            done = (accepted == '0);
            for (int k = 0; k < NCH; k++) begin
                if (src_q[k].size() != 0 || exp_q[k].size() != 0) done = 0;
            end
        end
        repeat (20) begin
            drive_cycle(100, 100, 100);
            if (o_trunc) ntr++;
        end
        n_vec++; if (!done) begin n_err++; $display("[TB] FAIL t5_timeout: streams not drained within budget, want drained"); end
        for (int k = 0; k < NCH; k++) begin
            n_vec++; if (exp_q[k].size() != 0) begin n_err++; $display("[TB] FAIL t5_missing_ch%0d: %0d beats not seen want 0", k, exp_q[k].size()); end
        end
        n_vec++; if (ntr != exp_trunc) begin n_err++; $display("[TB] FAIL t5_trunc_count: got %0d want %0d", ntr, exp_trunc); end
    endtask

    task automatic test_reset_mid_frame();
        int nb = 0;
        bit hit = 0, seen = 0;
        clear_tb();
        load_frame(0, 1, 1'b0, 8'h70);
        repeat (20) drive_cycle(100, 100, 100);
        load_frame(1, 6, 1'b0, 8'h60);
        for (int i = 0; i < 30 && !hit; i++) begin
            drive_cycle(100, 100, 100);
            if (o_hs) begin
                nb++;
                if (nb == 3) hit = 1;
            end
        end
        n_vec++; if (!hit) begin n_err++; $display("[TB] FAIL t6_reach_beat3: beat 3 not seen, want seen"); end
        reset = 1'b1;
        #1;
        n_vec++; if (m_tvalid !== 1'b0) begin n_err++; $display("[TB] FAIL t6_tvalid_drop: got %b want 0", m_tvalid); end
        n_vec++; if (s_tready !== 3'b000) begin n_err++; $display("[TB] FAIL t6_tready_drop: got %b want 000", s_tready); end
        clear_tb();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        load_frame(0, 2, 1'b0, 8'hC0);
        load_frame(1, 2, 1'b0, 8'hD0);
        for (int i = 0; i < 10 && !seen; i++) begin
            drive_cycle(100, 100, 100);
            if (o_hs) begin
                seen = 1;
                n_vec++;
                if (o_ch != 0 || o_data !== 8'hC0) begin
                    n_err++; $display("[TB] FAIL t6_first_grant: got ch %0d data %h want ch 0 data c0", o_ch, o_data);
                end
            end
        end
        n_vec++; if (!seen) begin n_err++; $display("[TB] FAIL t6_no_grant: no beat within budget, want one"); end
        repeat (20) drive_cycle(100, 100, 100);
    endtask

    // Default instance: no idle gap, limit far above a 10-beat frame.
    task automatic test_no_gap();
        logic [8:0] beats [13];
        int p = 0, q = 0, t_a = -1, t_b = -1, ntr = 0;
        bit acc = 0;
        for (int k = 0; k < 13; k++) begin
            beats[k] = (k < 3) ? {(k == 2), 8'hA0 + 8'(k)} : {(k == 12), 8'hB0 + 8'(k - 3)};
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (acc) begin
                p++;
                acc = 0;
            end
            d0_s_tvalid[0]    = (p < 13);
            d0_s_tdata[7:0]   = (p < 13) ? beats[p][7:0] : 8'h00;
            d0_s_tlast[0]     = (p < 13) ? beats[p][8] : 1'b0;
            d0_m_tready       = 1'b1;
            #1;
            if (d0_truncated) ntr++;
            if (d0_m_tvalid && d0_m_tready) begin
                n_vec++;
                if (q >= 13 || {d0_m_tlast, d0_m_tdata} !== beats[q] || d0_m_tchannel !== 2'd0) begin
                    n_err++;
                    $display("[TB] FAIL nogap_beat%0d: got %h ch %0d want %h ch 0", q, {d0_m_tlast, d0_m_tdata},
                             d0_m_tchannel, (q < 13) ? beats[q] : 9'h000);
                end
                if (q == 2) t_a = i;
                if (q == 3) t_b = i;
                q++;
            end
            if (d0_s_tvalid[0] && d0_s_tready[0]) acc = 1;
        end
        d0_s_tvalid = '0;
        n_vec++; if (q != 13) begin n_err++; $display("[TB] FAIL nogap_count: got %0d beats want 13", q); end
        n_vec++; if (t_b - t_a != 2) begin n_err++; $display("[TB] FAIL nogap_spacing: got %0d cycles want 2", t_b - t_a); end
        n_vec++; if (ntr != 0) begin n_err++; $display("[TB] FAIL nogap_truncated: got %0d pulses want 0", ntr); end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_gap();
        test_truncation();
        test_random();
        test_reset_mid_frame();
        test_no_gap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
